sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
- Parametrised successor to the team's synchronous FIFO: configurable width and depth, with non-power-of-two depth allowed.
- Almost-full and almost-empty thresholds are programmable; the block also provides an occupancy-level output and a synchronous flush.
- Same flag set as the existing FIFO: full, empty, almostfull, almostempty, overflow, underflow, wr_ack.
- Sits between producer and consumer blocks in one clock domain; it is the DUT for the next UVM environment and SVA checker.

Parameters:
- DATA_WIDTH, 16, width of din/dout.
- FIFO_DEPTH, 8, number of entries; must be >= 2; need not be a power of two.
- AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count >= AF_LEVEL and count < FIFO_DEPTH; legal range 1..FIFO_DEPTH-1.
- AE_LEVEL, 1, almostempty asserts when count <= AE_LEVEL and count > 0; legal range 1..FIFO_DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- rd_valid  out  1  dout carries a newly read word.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected because full.
- underflow  out  1  previous-cycle read rejected because empty.
- full, almostfull, empty, almostempty  out  1 each  occupancy flags.
- level  out  $clog2(FIFO_DEPTH+1)  current count.

Behaviour:
- Internal state: wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits, and count, same width as level.
- Pointer wrap: each pointer increments and wraps FIFO_DEPTH-1 -> 0 explicitly; no modulo-2^n wrap.
- Reset (rst high, asynchronous): ptrs=0, count=0, dout=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0.
  Resulting flags: empty=1, full=almostfull=almostempty=0. Memory contents are not reset.
- Accepted write: wr_en && !full at the rising edge. mem[wr_ptr] <= din, wr_ptr advances, wr_ack=1 next cycle.
- Rejected write: wr_en && full. No state change, overflow=1 and wr_ack=0 next cycle.
  A write is rejected when full even if rd_en is high in the same cycle.
- Accepted read: rd_en && !empty. rd_ptr advances.
- Rejected read: rd_en && empty. underflow=1 next cycle. A read is rejected when empty even if wr_en is high.
- count update: +1 when only a write is accepted; -1 when only a read is accepted; unchanged when both or neither are accepted.
- wr_ack, overflow, underflow are single-cycle registered pulses, cleared on any cycle without the triggering event.
- Flags are combinational from count:
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - almostfull and almostempty per the Parameters definitions; both are exclusive of full and empty.
  - level = count.
- Read latency (default): dout <= mem[rd_ptr] on an accepted read, rd_valid=1 for that one following cycle. dout holds its value otherwise.
- flush (rst low): same clearing as reset except dout holds its value. wr_en and rd_en in that cycle are ignored, with no ack/overflow/underflow.
- Priority: rst > flush > wr/rd.
- Out-of-range parameters raise $error at elaboration.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally whenever !empty; rd_valid = !empty.
  - rd_en pops the head word; the next word is visible in the same cycle the pop registers.
  - underflow rules are unchanged.
- Undefined: registered 1-cycle read latency as above.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2_depth
  - typedef ptr_t and cnt_t helpers parametrised via the functions
  - localparam defaults DEF_DATA_WIDTH=16 and DEF_FIFO_DEPTH=8
- Sub-module sync_fifo_ram: a 1-write/1-read register array with asynchronous read. It is shared by both read modes; the top holds pointers, count, flags and output registers.

Test Plan:
- Reset: assert rst mid-stream with count=5 -> level=0, empty=1 and all pulses 0 in the same cycle, without waiting for a clock edge.
- Fill to full: DEPTH=8, AF_LEVEL=6, write 0x0001..0x0008.
  - almostfull rises when level=6 and falls when level=8.
  - full=1 at level 8.
  - A 9th write -> overflow=1, wr_ack=0, level stays 8.
- Drain and read latency: DEPTH=8, AE_LEVEL=2, read 8 words.
  - dout=0x0001..0x0008, each valid one cycle after rd_en.
  - almostempty=1 at levels 2 and 1.
  - A further read -> underflow=1.
- Simultaneous events:
  - Level 3 with wr_en and rd_en both high -> level stays 3, wr_ack=1.
  - Empty with both high -> write accepted, underflow=1, level=1.
  - Full with both high -> read accepted, overflow=1, level=7.
- Non-power-of-two wrap: DEPTH=5, run 12 writes interleaved with reads -> data order preserved, wr_ptr goes 4 -> 0, no lost or duplicated word.
- Flush and FWFT: with SYNC_FIFO_FWFT_EN, write 0xAAAA -> dout=0xAAAA and rd_valid=1 with no rd_en.
  - flush with wr_en high -> empty=1 next cycle, wr_ack=0, write ignored.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Shared defaults, width helper and default-config types for the
//            programmable synchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Never returns 0 so a minimal depth still gets a real 1-bit pointer.
  function automatic int clog2_depth(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  typedef logic [clog2_depth(DEF_FIFO_DEPTH)-1:0]   ptr_t;
  typedef logic [clog2_depth(DEF_FIFO_DEPTH+1)-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog_if
// Purpose  : Producer/consumer bus of the programmable FIFO (master = user,
//            slave = FIFO).
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int LVL_W = clog2_depth(FIFO_DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic [LVL_W-1:0]      level;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, rd_valid, wr_ack, overflow, underflow,
           full, almostfull, empty, almostempty, level
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, rd_valid, wr_ack, overflow, underflow,
           full, almostfull, empty, almostempty, level
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ram
// Purpose  : 1-write / 1-read register array, synchronous write and
//            asynchronous read. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_prog
// Purpose  : Synchronous FIFO, any depth >= 2, programmable almost-full /
//            almost-empty levels, occupancy level and synchronous flush.
//            Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_prog_if.slave  bus
);

  localparam int PTR_W = clog2_depth(FIFO_DEPTH);
  localparam int CNT_W = clog2_depth(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_prog: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
    $error("sync_fifo_prog: AF_LEVEL must be in 1..FIFO_DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_LEVEL must be in 1..FIFO_DEPTH-1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rd_data;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.din),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Flush masks both requests so it never produces ack/overflow/underflow.
  always_comb begin
    full        = (count_q == CNT_FULL);
    empty       = (count_q == '0);
    wr_accept   = bus.wr_en && !full  && !bus.flush;
    rd_accept   = bus.rd_en && !empty && !bus.flush;
    wr_ack_d    = wr_accept;
    overflow_d  = bus.wr_en && full  && !bus.flush;
    underflow_d = bus.rd_en && empty && !bus.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; a pop simply moves rd_ptr to the next one.
  assign bus.dout     = rd_data;
  assign bus.rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    dout_d     = rd_accept ? rd_data : dout_q;
    rd_valid_d = rd_accept;
  end

  // dout survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= CNT_AF) && !full;
  assign bus.almostempty = (count_q <= CNT_AE) && !empty;
  assign bus.level       = count_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_prog
// Purpose  : Directed self-checking bench: depth-8 instance (AF=6, AE=2) and
//            depth-5 instance for non-power-of-two wrap. Honours
//            SYNC_FIFO_FWFT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) b8 ();
  sync_fifo_prog_if #(.DATA_WIDTH(16), .FIFO_DEPTH(5)) b5 ();

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2))
    dut8 (.clk(clk), .rst(rst), .bus(b8));
  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(5))
    dut5 (.clk(clk), .rst(rst), .bus(b5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_rd;
    b8.flush = 0; b8.wr_en = 0; b8.rd_en = 0; b8.din = '0;
    b5.flush = 0; b5.wr_en = 0; b5.rd_en = 0; b5.din = '0;
    tick();
    tick();
    rst = 0;

    // Reset state
    chk("rst_level", b8.level, 0);
    chk("rst_empty", b8.empty, 1);
    chk("rst_full", b8.full, 0);
    chk("rst_af", b8.almostfull, 0);
    chk("rst_ae", b8.almostempty, 0);
    chk("rst_wr_ack", b8.wr_ack, 0);
    chk("rst_ovf", b8.overflow, 0);
    chk("rst_udf", b8.underflow, 0);
    chk("rst_rd_valid", b8.rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", b8.dout, 0);
`endif

    // Fill to full
    for (int i = 1; i <= 8; i++) begin
      b8.wr_en = 1; b8.din = 16'(i);
      tick();
      chk("fill_wr_ack", b8.wr_ack, 1);
      chk("fill_level", b8.level, i);
      chk("fill_af", b8.almostfull, (i >= 6 && i < 8) ? 1 : 0);
      chk("fill_full", b8.full, (i == 8) ? 1 : 0);
      chk("fill_ae", b8.almostempty, (i <= 2) ? 1 : 0);
    end
    b8.din = 16'h0009;
    tick();
    chk("ovf_pulse", b8.overflow, 1);
    chk("ovf_wr_ack", b8.wr_ack, 0);
    chk("ovf_level", b8.level, 8);
    b8.wr_en = 0;

    // Drain
    for (int i = 1; i <= 8; i++) begin
      b8.rd_en = 1;
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_dout", b8.dout, i);
      chk("drain_valid", b8.rd_valid, 1);
      tick();
`else
      tick();
      chk("drain_dout", b8.dout, i);
      chk("drain_valid", b8.rd_valid, 1);
`endif
      chk("drain_level", b8.level, 8 - i);
      chk("drain_ae", b8.almostempty, (8 - i >= 1 && 8 - i <= 2) ? 1 : 0);
    end
    b8.rd_en = 0;
    tick();
    chk("idle_valid", b8.rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("idle_dout_hold", b8.dout, 16'h0008);
`endif
    b8.rd_en = 1;
    tick();
    chk("udf_pulse", b8.underflow, 1);
    chk("udf_level", b8.level, 0);
    b8.rd_en = 0;
    tick();
    chk("udf_clear", b8.underflow, 0);

    // Simultaneous read/write while empty
    b8.wr_en = 1; b8.rd_en = 1; b8.din = 16'h0011;
    tick();
    chk("sim_e_udf", b8.underflow, 1);
    chk("sim_e_ack", b8.wr_ack, 1);
    chk("sim_e_level", b8.level, 1);
    b8.rd_en = 0;
    b8.din = 16'h0022; tick();
    b8.din = 16'h0033; tick();
    chk("pre_sim_level", b8.level, 3);
    b8.rd_en = 1; b8.din = 16'h0044;
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_3_dout", b8.dout, 16'h0011);
`endif
    tick();
    chk("sim_3_level", b8.level, 3);
    chk("sim_3_ack", b8.wr_ack, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("sim_3_dout", b8.dout, 16'h0011);
`endif
    b8.rd_en = 0;
    for (int i = 0; i < 5; i++) begin
      b8.din = 16'h0055 + 16'(i * 16'h0011);
      tick();
    end
    chk("pre_full", b8.full, 1);

    // Simultaneous read/write while full
    b8.rd_en = 1; b8.din = 16'h00AA;
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_f_dout", b8.dout, 16'h0022);
`endif
    tick();
    chk("sim_f_level", b8.level, 7);
    chk("sim_f_ovf", b8.overflow, 1);
    chk("sim_f_ack", b8.wr_ack, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("sim_f_dout", b8.dout, 16'h0022);
    chk("sim_f_valid", b8.rd_valid, 1);
`endif

    // Flush with write request pending
    b8.rd_en = 0; b8.flush = 1; b8.din = 16'h00BB;
    tick();
    chk("flush_empty", b8.empty, 1);
    chk("flush_level", b8.level, 0);
    chk("flush_ack", b8.wr_ack, 0);
    chk("flush_ovf", b8.overflow, 0);
    chk("flush_valid", b8.rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("flush_dout_hold", b8.dout, 16'h0022);
`endif
    b8.flush = 0; b8.din = 16'hAAAA;
    tick();
    b8.wr_en = 0;
    chk("post_flush_level", b8.level, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_dout", b8.dout, 16'hAAAA);
    chk("fwft_valid", b8.rd_valid, 1);
`else
    chk("nofwft_valid", b8.rd_valid, 0);
`endif
    b8.rd_en = 1;
    tick();
    b8.rd_en = 0;
    chk("pop_aaaa_level", b8.level, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("pop_aaaa_dout", b8.dout, 16'hAAAA);
`endif

    // Asynchronous reset mid-stream
    b8.wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      b8.din = 16'h0100 + 16'(i);
      tick();
    end
    chk("pre_rst_level", b8.level, 5);
    #2 rst = 1;
    #1;
    chk("arst_level", b8.level, 0);
    chk("arst_empty", b8.empty, 1);
    chk("arst_ack", b8.wr_ack, 0);
    chk("arst_ovf", b8.overflow, 0);
    chk("arst_udf", b8.underflow, 0);
    chk("arst_valid", b8.rd_valid, 0);
    b8.wr_en = 0;
    tick();
    rst = 0;
    tick();

    // Depth-5 wrap with interleaved reads
    exp_rd = 16'h0100;
    for (int k = 0; k < 12; k++) begin
      b5.wr_en = 1; b5.din = 16'h0100 + 16'(k);
      b5.rd_en = (k >= 3);
`ifdef SYNC_FIFO_FWFT_EN
      if (k >= 3) chk("wrap_dout", b5.dout, exp_rd);
`endif
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      if (k >= 3) begin
        chk("wrap_dout", b5.dout, exp_rd);
        chk("wrap_valid", b5.rd_valid, 1);
      end
`endif
      if (k >= 3) exp_rd++;
      chk("wrap_wr_ptr", dut5.wr_ptr_q, (k + 1) % 5);
      chk("wrap_level", b5.level, (k < 3) ? k + 1 : 3);
    end
    b5.wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      b5.rd_en = 1;
`ifdef SYNC_FIFO_FWFT_EN
      chk("wrap_tail_dout", b5.dout, exp_rd);
      tick();
`else
      tick();
      chk("wrap_tail_dout", b5.dout, exp_rd);
`endif
      exp_rd++;
    end
    b5.rd_en = 0;
    tick();
    chk("wrap_end_empty", b5.empty, 1);
    chk("wrap_end_udf", b5.underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
